// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: op encodings, FSM states and op-class helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } alu_state_e;

    // True for ops that go through the iterative shifter.
    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter_iter.sv
// Iterative shifter: loads an operand and shift amount, then shifts by up to
// SHIFT_STEP bits per cycle until the remaining count reaches zero.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        capture data_in, shamt_in, dir, arith
//   dir         1 = right shift, 0 = left shift (sampled on load)
//   arith       1 = sign-fill on right shift (sampled on load)
//   data_in     operand to shift
//   shamt_in    total shift amount
//   result_c    value after the current cycle's step (combinational)
//   done_c      the current cycle's step is the final one (combinational)
module alu_shifter_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       dir,
    input  logic                       arith,
    input  logic [XLEN-1:0]            data_in,
    input  logic [$clog2(XLEN)-1:0]    shamt_in,
    output logic [XLEN-1:0]            result_c,
    output logic                       done_c
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    // One extra bit so SHIFT_STEP == XLEN is representable.
    localparam int unsigned CNT_W   = SHAMT_W + 1;

    logic [XLEN-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic [CNT_W-1:0]   step;
    logic [XLEN-1:0]    shifted;

    // Step = min(SHIFT_STEP, remaining); compute the shifted value and next state.
    always_comb begin
        data_d  = data_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        arith_d = arith_q;

        step = (CNT_W'(rem_q) < CNT_W'(SHIFT_STEP)) ? CNT_W'(rem_q) : CNT_W'(SHIFT_STEP);

        if (!dir_q) begin
            shifted = data_q << step;
        end else if (arith_q) begin
            shifted = $signed(data_q) >>> step;
        end else begin
            shifted = data_q >> step;
        end

        result_c = shifted;
        done_c   = (rem_q != '0) && (CNT_W'(rem_q) <= CNT_W'(SHIFT_STEP));

        if (load) begin
            data_d  = data_in;
            rem_d   = shamt_in;
            dir_d   = dir;
            arith_d = arith;
        end else if (rem_q != '0) begin
            data_d = shifted;
            // step never exceeds rem_q here, so it fits in SHAMT_W bits.
            rem_d  = rem_q - SHAMT_W'(step);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked RV32I-style ALU: single-cycle logic/arith/compare ops and an
// iterative shifter, with registered result, zero and illegal-op flags.
// Ports:
//   clk, rst_n           clock / async active-low reset
//   in_valid, in_ready   request handshake (in_ready is combinational from out_ready)
//   alu_sel, reg1, reg2  op select and operands, sampled on accept
//   out_valid, out_ready response handshake
//   ALU_Out, zero, illegal  registered result and flags
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_Out,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    alu_state_e         state_q, state_d;
    logic [XLEN-1:0]    alu_out_q, alu_out_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    alu_op_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    op_res;
    logic               op_ill;
    logic               accept;
    logic               sh_load;
    logic [XLEN-1:0]    sh_result;
    logic               sh_done;

    assign op     = alu_op_e'(alu_sel);
    assign shamt  = reg2[SHAMT_W-1:0];

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_RESP);
    assign ALU_Out   = alu_out_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Single-cycle op unit; shifts pass reg1 through (only used when shamt is zero).
    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        case (op)
            ALU_ADD:  op_res = reg1 + reg2;
            ALU_SUB:  op_res = reg1 - reg2;
            ALU_AND:  op_res = reg1 & reg2;
            ALU_OR:   op_res = reg1 | reg2;
            ALU_XOR:  op_res = reg1 ^ reg2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  op_res = reg1;
            ALU_SLT:  op_res = {{(XLEN-1){1'b0}}, ($signed(reg1) < $signed(reg2))};
            ALU_SLTU: op_res = {{(XLEN-1){1'b0}}, (reg1 < reg2)};
            default:  op_ill = 1'b1;
        endcase
    end

    alu_shifter_iter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .dir      (op != ALU_SLL),
        .arith    (op == ALU_SRA),
        .data_in  (reg1),
        .shamt_in (shamt),
        .result_c (sh_result),
        .done_c   (sh_done)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        sh_load   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if ((state_q == ST_RESP) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_shift(op) && (shamt != '0)) begin
                        sh_load = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        alu_out_d = op_res;
                        zero_d    = (op_res == '0);
                        illegal_d = op_ill;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    alu_out_d = sh_result;
                    zero_d    = (sh_result == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (XLEN=32, SHIFT_STEP=1): directed vectors with
// hand-computed results and latencies, plus a per-cycle scoreboard against a
// plain-arithmetic reference model.
module tb_alu_iter;
    import alu_pkg::*;

    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } row_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_Out;
    logic            zero;
    logic            illegal;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];
    row_t rows [15];

    alu_iter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .reg1      (reg1),
        .reg2      (reg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result of one op from the op table, straight arithmetic.
    function automatic exp_t exp_of(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh;
        sh    = int'(b % 32);
        e.ill = 1'b0;
        case (sel)
            4'd0:    e.res = a + b;
            4'd1:    e.res = a - b;
            4'd2:    e.res = a & b;
            4'd3:    e.res = a | b;
            4'd4:    e.res = a ^ b;
            4'd5:    e.res = a << sh;
            4'd6:    e.res = a >> sh;
            4'd7:    e.res = $signed(a) >>> sh;
            4'd8:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    e.res = (a < b) ? 32'd1 : 32'd0;
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Scoreboard: every cycle out_valid is high, outputs must match the oldest pending request.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mon_unexpected: got out_valid=1, expected 0 (nothing pending) at %0t", $time);
                end else begin
                    check("mon_res", ALU_Out, exp_q[0].res);
                    check("mon_zero", 32'(zero), 32'(exp_q[0].z));
                    check("mon_illegal", 32'(illegal), 32'(exp_q[0].ill));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(exp_of(alu_sel, reg1, reg2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, measure latency to out_valid, check result and flags.
    task automatic run_op(input int idx, input row_t r);
        int lat;
        tick();
        alu_sel  = r.sel;
        reg1     = r.a;
        reg2     = r.b;
        in_valid = 1'b1;
        @(negedge clk);
        check($sformatf("row%0d accept_ready", idx), 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            check($sformatf("row%0d busy_ready", idx), 32'(in_ready), 32'd0);
            tick();
            @(negedge clk);
            lat++;
        end
        check($sformatf("row%0d latency", idx), 32'(lat), 32'(r.lat));
        check($sformatf("row%0d result", idx), ALU_Out, r.res);
        check($sformatf("row%0d zero", idx), 32'(zero), 32'(r.z));
        check($sformatf("row%0d illegal", idx), 32'(illegal), 32'(r.ill));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;

        rows[0]  = '{4'(ALU_ADD),  32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1};
        rows[1]  = '{4'(ALU_AND),  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1'b0, 1};
        rows[2]  = '{4'(ALU_OR),   32'h0000_1234,  32'h8000_0000,  32'h8000_1234,  1'b0, 1'b0, 1};
        rows[3]  = '{4'(ALU_SUB),  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 1};
        rows[4]  = '{4'(ALU_SRA),  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 5};
        rows[5]  = '{4'(ALU_SRL),  32'h8000_0000,  32'h24,         32'h0800_0000,  1'b0, 1'b0, 5};
        rows[6]  = '{4'(ALU_SLL),  32'd3,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32};
        rows[7]  = '{4'(ALU_SLL),  32'hA5A5_A5A5,  32'h20,         32'hA5A5_A5A5,  1'b0, 1'b0, 1};
        rows[8]  = '{4'(ALU_SLT),  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1};
        rows[9]  = '{4'(ALU_SLTU), 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1};
        rows[10] = '{4'b1111,      32'd123,        32'd456,        32'd0,          1'b1, 1'b1, 1};
        rows[11] = '{4'b1010,      32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1};
        rows[12] = '{4'(ALU_SRA),  32'h7FFF_FFF0,  32'h1F,         32'd0,          1'b1, 1'b0, 32};
        rows[13] = '{4'(ALU_SRL),  32'hFFFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 2};
        rows[14] = '{4'(ALU_XOR),  32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  1'b0, 1'b0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_sel   = 4'd0;
        reg1      = '0;
        reg2      = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst ALU_Out", ALU_Out, 32'd0);
        check("rst zero", 32'(zero), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;

        foreach (rows[i]) run_op(i, rows[i]);

        // Back-to-back SUB then XOR with out_ready held high.
        tick();
        alu_sel = 4'(ALU_SUB); reg1 = 32'd3; reg2 = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        check("b2b accept1", 32'(in_ready), 32'd1);
        tick();
        alu_sel = 4'(ALU_XOR); reg1 = 32'hFFFF_0000; reg2 = 32'hFFFF_0000;
        @(negedge clk);
        check("b2b out_valid1", 32'(out_valid), 32'd1);
        check("b2b res1", ALU_Out, 32'hFFFF_FFFE);
        check("b2b in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b out_valid2", 32'(out_valid), 32'd1);
        check("b2b res2", ALU_Out, 32'd0);
        check("b2b zero2", 32'(zero), 32'd1);

        // Backpressure: result held for 3 cycles, then release with a new request waiting.
        tick();
        alu_sel = 4'(ALU_ADD); reg1 = 32'd10; reg2 = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("bp accept", 32'(in_ready), 32'd1);
        tick();
        alu_sel = 4'(ALU_SUB); reg1 = 32'd9; reg2 = 32'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d res", i), ALU_Out, 32'd30);
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release res", ALU_Out, 32'd30);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp next out_valid", 32'(out_valid), 32'd1);
        check("bp next res", ALU_Out, 32'd0);
        check("bp next zero", 32'(zero), 32'd1);

        // Reset during a long shift aborts it silently.
        run_op(100, rows[0]);
        tick();
        alu_sel = 4'(ALU_SLL); reg1 = 32'd1; reg2 = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("shift hold ALU_Out", ALU_Out, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst ALU_Out", ALU_Out, 32'd0);
        check("async rst zero", 32'(zero), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst in_ready", 32'(in_ready), 32'd1);
        check("post rst out_valid", 32'(out_valid), 32'd0);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("no stale result", 32'(hits), 32'd0);
        run_op(101, rows[14]);
        tick();
        @(negedge clk);
        check("final idle out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
